// File: rtl/pwm_pkg.sv
// Shared types and elaboration helpers for the PWM generator.
// MAX_CHUNKS fixes the duty resolution at 8 bits. Each PWM period is
// 256 chunks of CHUNK_SIZE clocks.
package pwm_pkg;

    localparam int MAX_CHUNKS = 256;
    localparam int DUTY_W     = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    // Clocks per chunk. This is the integer floor of the clocks per period
    // divided by the chunk count, so the real period can be slightly shorter
    // than 1/PWM_FREQ.
    function automatic int chunk_size(input int clock, input int freq);
        int pulse;
        pulse = clock / freq;
        return pulse / MAX_CHUNKS;
    endfunction

    // Width of a counter that runs 0..n-1. It is never narrower than one bit,
    // so a one-clock chunk still gets a legal register.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Chunk prescaler. It counts clocks inside one chunk and raises a
// single-cycle strobe on the last clock of every chunk.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CHUNK_SIZE = 7
) (
    input  logic clk,
    input  logic clr,
    output logic chunk_o
);

    localparam int            CW   = counter_width(CHUNK_SIZE);
    localparam logic [CW-1:0] LAST = CW'(CHUNK_SIZE - 1);

    logic [CW-1:0] clocks_q;
    logic [CW-1:0] clocks_d;

    // Next count. It wraps to zero after the last clock of the chunk.
    always_comb begin
        clocks_d = clocks_q;
        if (clocks_q == LAST) begin
            clocks_d = '0;
        end else begin
            clocks_d = clocks_q + CW'(1);
        end
    end

    // Clock counter register. clr restarts the chunk.
    always_ff @(posedge clk) begin
        if (clr) begin
            clocks_q <= '0;
        end else begin
            clocks_q <= clocks_d;
        end
    end

    // The strobe is decoded straight from the count, so it lines up with the
    // cycle in which the chunk index has to advance.
    assign chunk_o = (clocks_q == LAST);

endmodule

// File: rtl/pwm_generator.sv
// Fixed-frequency, 8-bit PWM generator.
// The period is 256 chunks of CHUNK_SIZE clocks. pwm is high while the chunk
// index is below the effective duty. pwm is registered, so it trails the
// counters by one clock.
// Optional build macro PWM_SYNC_DUTY_EN: when defined, a new duty is taken
// only at the period boundary, which keeps every pulse whole. When undefined,
// the duty is resampled every clock.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CLOCK    = 100000,
    parameter int PWM_FREQ = 50
) (
    input  logic  clk,
    input  logic  clr,
    input  duty_t duty_cycle,
    output logic  pwm
);

    localparam int PULSE_SIZE = CLOCK / PWM_FREQ;
    localparam int CHUNK_SIZE = chunk_size(CLOCK, PWM_FREQ);
    // The prescaler is always built legally. A bad ratio is stopped by the
    // check below instead.
    localparam int PRESC_SIZE = (CHUNK_SIZE < 1) ? 1 : CHUNK_SIZE;

    // A period shorter than 256 clocks cannot hold 256 chunks.
    if (PULSE_SIZE < MAX_CHUNKS) begin : g_bad_ratio
        $fatal(1, "pwm_generator: CLOCK/PWM_FREQ must be at least 256");
    end

    logic  chunk_s;
    duty_t chunk_count_q;
    duty_t chunk_count_d;
    duty_t duty_q;
    duty_t duty_d;
    logic  pwm_q;
    logic  pwm_d;

    pwm_prescaler #(
        .CHUNK_SIZE (PRESC_SIZE)
    ) u_presc (
        .clk     (clk),
        .clr     (clr),
        .chunk_o (chunk_s)
    );

    // Chunk index. It advances once per chunk and wraps 255 -> 0 by natural
    // overflow, which starts the next period.
    always_comb begin
        chunk_count_d = chunk_count_q;
        if (chunk_s) begin
            chunk_count_d = chunk_count_q + 8'd1;
        end else begin
            chunk_count_d = chunk_count_q;
        end
    end

`ifdef PWM_SYNC_DUTY_EN
    logic period_end_s;

    assign period_end_s = chunk_s && (chunk_count_q == 8'd255);

    // The duty is held for the whole period and is reloaded only on its
    // final clock.
    always_comb begin
        duty_d = duty_q;
        if (period_end_s) begin
            duty_d = duty_cycle;
        end else begin
            duty_d = duty_q;
        end
    end
`else
    // The duty follows the input every clock. A mid-period change can
    // shorten or stretch the pulse that is in progress.
    always_comb begin
        duty_d = duty_cycle;
    end
`endif

    // Compare. The output is high for the first duty_q chunks of each period.
    always_comb begin
        pwm_d = 1'b0;
        if (chunk_count_q < duty_q) begin
            pwm_d = 1'b1;
        end else begin
            pwm_d = 1'b0;
        end
    end

    // State and output registers. clr overrides counting and restarts the
    // period at chunk 0 with the current input duty.
    always_ff @(posedge clk) begin
        if (clr) begin
            chunk_count_q <= 8'd0;
            duty_q        <= duty_cycle;
            pwm_q         <= 1'b0;
        end else begin
            chunk_count_q <= chunk_count_d;
            duty_q        <= duty_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator at the default parameters, plus a
// second instance with CLOCK overridden to 1 MHz.
module tb_pwm_generator;

    localparam int CHUNK  = 7;
    localparam int PERIOD = 1792;
`ifdef PWM_SYNC_DUTY_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] duty_cycle;
    logic       pwm;
    logic       clr2;
    logic [7:0] duty2;
    logic       pwm2;

    int n_vec = 0;
    int n_err = 0;

    bit exp_q[$];
    int hi_q[$];
    int lo_q[$];

    int m_t;
    int m_dq;
    int m_cnt;

    int mon_run;
    bit mon_lvl;

    always #5 clk = ~clk;

    pwm_generator dut (
        .clk        (clk),
        .clr        (clr),
        .duty_cycle (duty_cycle),
        .pwm        (pwm)
    );

    pwm_generator #(
        .CLOCK    (1000000),
        .PWM_FREQ (50)
    ) dut2 (
        .clk        (clk),
        .clr        (clr2),
        .duty_cycle (duty2),
        .pwm        (pwm2)
    );

    // Reference model: the expected pwm after each edge is derived from the
    // elapsed cycles since reset release.
    always @(posedge clk) begin
        if (clr) begin
            m_t  = 0;
            m_dq = int'(duty_cycle);
            exp_q.push_back(1'b0);
        end else begin
            m_cnt = (m_t / CHUNK) % 256;
            exp_q.push_back(m_cnt < m_dq);
            if (SYNC) begin
                if ((m_t % PERIOD) == PERIOD - 1) m_dq = int'(duty_cycle);
            end else begin
                m_dq = int'(duty_cycle);
            end
            m_t = m_t + 1;
        end
    end

    // Scoreboard: compare the DUT output against the expected value queued
    // at the previous edge.
    always @(negedge clk) begin
        bit e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (pwm !== e) begin
                n_err++;
                $display("FAIL sb_pwm t=%0t got %b want %b", $time, pwm, e);
            end
        end
    end

    // Run-length monitor: each completed high run and low run is recorded.
    always @(negedge clk) begin
        if (clr) begin
            mon_lvl = 1'b0;
            mon_run = 0;
        end else if (pwm === mon_lvl) begin
            mon_run++;
        end else begin
            if (mon_run > 0) begin
                if (mon_lvl) hi_q.push_back(mon_run);
                else         lo_q.push_back(mon_run);
            end
            mon_lvl = pwm;
            mon_run = 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic flush_runs();
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic wait_runs(input int nh, input int nl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (hi_q.size() >= nh && lo_q.size() >= nl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        duty_cycle = 8'd128;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (pwm !== 1'b0) begin
                n_err++;
                $display("FAIL reset_pwm got %b want 0", pwm);
            end
            n_vec++;
            if (dut.chunk_count_q !== 8'd0) begin
                n_err++;
                $display("FAIL reset_chunk_count got %0d want 0", dut.chunk_count_q);
            end
            n_vec++;
            if (dut.u_presc.clocks_q !== 3'd0) begin
                n_err++;
                $display("FAIL reset_clocks got %0d want 0", dut.u_presc.clocks_q);
            end
        end
    endtask

    task automatic test_duty_128();
        bit ok;
        flush_runs();
        clr = 1'b0;
        wait_runs(3, 3, 7000, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL d128_timeout got %0d/%0d runs want 3/3", hi_q.size(), lo_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (hi_q[i] != 896) begin
                    n_err++;
                    $display("FAIL d128_high[%0d] got %0d want 896", i, hi_q[i]);
                end
                n_vec++;
                if (lo_q[i] != 896) begin
                    n_err++;
                    $display("FAIL d128_low[%0d] got %0d want 896", i, lo_q[i]);
                end
            end
        end
    endtask

    task automatic test_duty_change();
        bit ok;
        int exp_hi0;
        int exp_lo0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (mon_lvl && mon_run == 100) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL chg_sync_timeout got none want pulse start");
        end else begin
            duty_cycle = 8'd64;
            flush_runs();
            exp_hi0 = SYNC ? 896 : 448;
            exp_lo0 = SYNC ? 896 : 1344;
            wait_runs(2, 2, 6000, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL chg_timeout got %0d/%0d runs want 2/2", hi_q.size(), lo_q.size());
            end else begin
                n_vec++;
                if (hi_q[0] != exp_hi0) begin
                    n_err++;
                    $display("FAIL chg_cur_high got %0d want %0d", hi_q[0], exp_hi0);
                end
                n_vec++;
                if (lo_q[0] != exp_lo0) begin
                    n_err++;
                    $display("FAIL chg_cur_low got %0d want %0d", lo_q[0], exp_lo0);
                end
                n_vec++;
                if (hi_q[1] != 448) begin
                    n_err++;
                    $display("FAIL chg_next_high got %0d want 448", hi_q[1]);
                end
                n_vec++;
                if (lo_q[1] != 1344) begin
                    n_err++;
                    $display("FAIL chg_next_low got %0d want 1344", lo_q[1]);
                end
            end
        end
    endtask

    task automatic test_duty_zero();
        int highs;
        duty_cycle = 8'd0;
        for (int i = 0; i < PERIOD + 8; i++) tick();
        highs = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            if (pwm !== 1'b0) highs++;
        end
        n_vec++;
        if (highs != 0) begin
            n_err++;
            $display("FAIL duty0_highs got %0d want 0", highs);
        end
    endtask

    task automatic test_duty_255();
        bit ok;
        duty_cycle = 8'd255;
        for (int i = 0; i < PERIOD + 8; i++) tick();
        flush_runs();
        wait_runs(3, 3, 8000, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL d255_timeout got %0d/%0d runs want 3/3", hi_q.size(), lo_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (lo_q[i] != 7) begin
                    n_err++;
                    $display("FAIL d255_low[%0d] got %0d want 7", i, lo_q[i]);
                end
                n_vec++;
                if (hi_q[i] != 1785) begin
                    n_err++;
                    $display("FAIL d255_high[%0d] got %0d want 1785", i, hi_q[i]);
                end
            end
        end
    endtask

    task automatic test_counter_bounds();
        int last_chunk;
        bit prev_wrap;
        bit pend_high;
        int wraps;
        last_chunk = -1;
        prev_wrap  = 1'b0;
        pend_high  = 1'b0;
        wraps      = 0;
        for (int i = 0; i < 2 * PERIOD + 16; i++) begin
            tick();
            n_vec++;
            if (dut.u_presc.clocks_q > 3'd6) begin
                n_err++;
                $display("FAIL bnd_clocks got %0d want <=6", dut.u_presc.clocks_q);
            end
            if (pend_high) begin
                n_vec++;
                if (pwm !== 1'b1) begin
                    n_err++;
                    $display("FAIL bnd_wrap_rise got %b want 1", pwm);
                end
                pend_high = 1'b0;
            end
            if (prev_wrap) begin
                wraps++;
                n_vec++;
                if (dut.chunk_count_q !== 8'd0) begin
                    n_err++;
                    $display("FAIL bnd_wrap_count got %0d want 0", dut.chunk_count_q);
                end
                n_vec++;
                if (pwm !== 1'b0) begin
                    n_err++;
                    $display("FAIL bnd_wrap_low got %b want 0", pwm);
                end
                pend_high = 1'b1;
            end
            prev_wrap = 1'b0;
            if (dut.chunk_s === 1'b1) begin
                if (last_chunk >= 0) begin
                    n_vec++;
                    if (i - last_chunk != CHUNK) begin
                        n_err++;
                        $display("FAIL bnd_strobe_gap got %0d want 7", i - last_chunk);
                    end
                end
                last_chunk = i;
                if (dut.chunk_count_q === 8'd255) prev_wrap = 1'b1;
            end
        end
        n_vec++;
        if (wraps < 2) begin
            n_err++;
            $display("FAIL bnd_wrap_seen got %0d want >=2", wraps);
        end
    endtask

    task automatic test_param_override();
        int hi;
        int lo;
        bit ok;
        n_vec++;
        if (dut2.CHUNK_SIZE != 78) begin
            n_err++;
            $display("FAIL ovr_chunk_size got %0d want 78", dut2.CHUNK_SIZE);
        end
        clr2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pwm2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        hi = 0;
        lo = 0;
        if (ok) begin
            while (pwm2 === 1'b1 && hi < 12000) begin
                hi++;
                tick();
            end
            while (pwm2 === 1'b0 && lo < 12000) begin
                lo++;
                tick();
            end
        end
        n_vec++;
        if (hi != 9984) begin
            n_err++;
            $display("FAIL ovr_high got %0d want 9984", hi);
        end
        n_vec++;
        if (lo != 9984) begin
            n_err++;
            $display("FAIL ovr_low got %0d want 9984", lo);
        end
        n_vec++;
        if (hi + lo != 19968) begin
            n_err++;
            $display("FAIL ovr_period got %0d want 19968", hi + lo);
        end
    endtask

    initial begin
        clr        = 1'b1;
        duty_cycle = 8'd128;
        clr2       = 1'b1;
        duty2      = 8'd128;
        test_reset();
        test_duty_128();
        test_duty_change();
        test_duty_zero();
        test_duty_255();
        test_counter_bounds();
        test_param_override();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
